mux_nto1_stream: RTL and testbench
==================================

Name: mux_nto1_stream

Overview:
- Parametrised N-input, W-bit multiplexer with a registered output and valid/ready handshakes on every input and on the output.
- Two selection modes:
  - manual: an external select picks the input, like a classic 4:1 MUX.
  - round-robin: the block arbitrates fairly among the valid inputs.
- Sits between several producer channels and a single consumer; it is the streaming successor of the combinational 4-to-1 mux.

Parameters:
- N, 4, number of input channels (2..16).
- W, 1, data width per channel in bits.
- SW, $clog2(N) (localparam, derived), width of the select and source fields.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = manual select, 1 = round-robin.
- sel  input  SW  channel index used in manual mode.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; combinational.
- out_data  output  W  registered selected data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_src  output  SW  index of the channel that produced out_data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0.
  - in_ready is forced to all zeros while rst=1.
  - Any word held in the output register is discarded.
- load_en = !out_valid || out_ready. The output register is either empty or being drained this cycle.
- Grant, manual mode:
  - candidate = sel.
  - Grant if sel < N and in_valid[sel]=1.
  - sel >= N: no grant and no error flag; the output simply stays idle.
- Grant, round-robin mode:
  - Scan indices ptr, ptr+1, ..., wrapping modulo N.
  - Grant the first index whose in_valid bit is 1.
  - No valid input means no grant.
- in_ready[g] = load_en && grant && (g == granted index). All other in_ready bits are 0.
  - Exactly one transfer per cycle at most.
  - in_ready depends on in_valid, so producers must not make in_valid depend on in_ready.
- On a clk edge with load_en=1:
  - If there is a grant: out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - If there is no grant: out_valid <= 0; out_data and out_src hold their old values.
- On a clk edge with load_en=0 (out_valid=1, out_ready=0): out_data, out_src and out_valid hold. No input is accepted.
- ptr update:
  - ptr <= (g+1) mod N on every round-robin-mode transfer.
  - Unchanged otherwise, including during manual-mode transfers.
  - Wrap: g=N-1 gives ptr=0.
- Latency and throughput:
  - An input is accepted at edge k and appears on out_data at edge k (registered); the consumer sees it in cycle k+1.
  - Sustained throughput is 1 word/cycle when out_ready stays high.
- Mode or sel changes take effect at the next load. An already-registered word is never altered.
- Simultaneous out_ready=1 and a new grant: drain and reload in the same cycle, with no bubble.
- Fairness: in round-robin mode with all N inputs continuously valid, each channel is granted exactly once every N transfers.
- No internal FSM beyond the output register (empty/full) and ptr. Empty/full is encoded by out_valid.

Decomposition:
- Shared package mux_pkg:
  - MODE_MANUAL=1'b0, MODE_RR=1'b1.
  - A function for rotating priority search (first set bit at or after ptr, modulo N), reused by future arbiters.
- One sub-module is natural: rr_arbiter_n.
  - Parameter N.
  - Inputs: req[N], ptr[SW].
  - Outputs: gnt_onehot[N], gnt_idx[SW], gnt_any.
  - Purely combinational.
- The top level holds ptr, the output register and the manual/RR grant muxing.

Test Plan:
- Reset: assert rst with all in_valid=1 and out_ready=1 → in_ready=0000, then out_valid=0, out_data=0, out_src=0 after the edge. Deassert → first RR transfer comes from channel 0.
- Manual, N=4, W=8: in_data={8'hDD,8'hCC,8'hBB,8'hAA}, all valid, sel stepping 3,2,1,0 per cycle, out_ready=1 → out_data DD,CC,BB,AA one cycle later each, out_src 3,2,1,0. No valid input gives no grant.
- Manual sel with in_valid[sel]=0, e.g. sel=2, in_valid=1011 → in_ready=0000 and out_valid falls to 0 after the edge.
- Round-robin fairness: all four valid for 8 cycles, out_ready=1 → out_src sequence 0,1,2,3,0,1,2,3. Then in_valid=1010 → 1,3,1,3.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles → out_data stable, in_ready=0000. Raise out_ready → the next word loads on that same edge with no idle cycle.
- Mid-operation reset: during RR streaming with ptr=2 and out_valid=1, pulse rst for one cycle → the held word is dropped, ptr=0, and the next grant goes to the lowest-index valid channel.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for streaming muxes and arbiters: mode encoding and a
// rotating-priority search helper.
package mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;
  localparam int   RR_MAX_N    = 16;

  typedef struct packed {
    logic       any;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping modulo n. ptr must be < n.
  function automatic rr_pick_t rr_first(input logic [RR_MAX_N-1:0] req,
                                        input logic [3:0] ptr, input int n);
    rr_pick_t   r;
    logic [4:0] j;
    r = '0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      if (k < n) begin
        j = {1'b0, ptr} + 5'(k);
        if (j >= 5'(n)) j = j - 5'(n);
        if (!r.any && req[j[3:0]]) begin
          r.any = 1'b1;
          r.idx = j[3:0];
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/mux_nto1_stream_if.sv
// N producer channels plus one consumer channel, valid/ready on each side.
interface mux_nto1_stream_if #(
  parameter int N = 4,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_ready;
  logic [W-1:0]        out_data;
  logic                out_valid;
  logic                out_ready;
  logic [SW-1:0]       out_src;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational rotating-priority arbiter: grants the first requester at or
// after ptr.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);
  rr_pick_t pick;

  always_comb pick = rr_first(RR_MAX_N'(req), 4'(ptr), N);

  assign gnt_any    = pick.any;
  assign gnt_idx    = SW'(pick.idx);
  assign gnt_onehot = pick.any ? (N'(1) << pick.idx) : '0;
endmodule

// File: rtl/mux_nto1_stream.sv
// N:1 streaming mux with a registered output stage, manual or round-robin
// source selection, and a per-channel combinational accept.
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 1,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  mux_nto1_stream_if.slave bus
);
  logic          load_en, grant;
  logic [SW-1:0] gidx, ptr;
  logic [N-1:0]  man_oh, rr_oh, gnt_oh;
  logic [SW-1:0] rr_idx;
  logic          rr_any;
  logic [W-1:0]  data_q;
  logic [SW-1:0] src_q;
  logic          vld_q;

  rr_arbiter_n #(.N(N)) u_arb (
    .req        (bus.in_valid),
    .ptr        (ptr),
    .gnt_onehot (rr_oh),
    .gnt_idx    (rr_idx),
    .gnt_any    (rr_any)
  );

  // An out-of-range sel matches no channel, so the output just idles.
  always_comb begin
    man_oh = '0;
    for (int i = 0; i < N; i++)
      man_oh[i] = bus.in_valid[i] && (sel == SW'(i));
  end

  assign load_en = !vld_q || bus.out_ready;
  assign gnt_oh  = (mode == MODE_RR) ? rr_oh  : man_oh;
  assign gidx    = (mode == MODE_RR) ? rr_idx : sel;
  assign grant   = (mode == MODE_RR) ? rr_any : |man_oh;

  assign bus.in_ready = (!rst && load_en && grant) ? gnt_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      src_q  <= '0;
      ptr    <= '0;
    end else if (load_en) begin
      if (grant) begin
        data_q <= bus.in_data[gidx];
        src_q  <= gidx;
        vld_q  <= 1'b1;
        // Pointer only tracks round-robin transfers; manual ones leave it.
        if (mode == MODE_RR)
          ptr <= (gidx == SW'(N-1)) ? '0 : gidx + 1'b1;
      end else begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream (N=4, W=8): stimulus queues expected
// words, a negedge monitor pops them on every output handshake.
module tb_mux_nto1_stream;
  import mux_pkg::*;
  localparam int N = 4;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst, mode;
  logic [1:0] sel;

  always #5 clk = ~clk;

  mux_nto1_stream_if #(.N(N), .W(W)) bus ();

  mux_nto1_stream #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sel  (sel),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   s;
  } exp_t;

  exp_t         exp_q[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] dv[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output word must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon_unexpected: got word %0h src %0d, required no word",
                 bus.out_data, bus.out_src);
      end else begin
        e = exp_q.pop_front();
        chk("mon_data", 32'(bus.out_data), 32'(e.d));
        chk("mon_src",  32'(bus.out_src),  32'(e.s));
      end
    end
  end

  initial begin
    dv = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rst  = 1'b1;
    mode = MODE_RR;
    sel  = 2'd0;
    bus.in_data   = {dv[3], dv[2], dv[1], dv[0]};
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;

    // Reset with everything asserted
    #2 chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_out_src",   32'(bus.out_src),   32'h0);
    step();
    rst = 1'b0;

    // Round-robin fairness, all valid: 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_all_in_ready", 32'(bus.in_ready), 32'(1) << (k % 4));
      exp_q.push_back('{d: dv[k % 4], s: 2'(k % 4)});
      step();
    end

    // Round-robin, channels 1 and 3 only: 1,3,1,3
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      int ch;
      ch = (k % 2 == 1) ? 3 : 1;
      #1 chk("rr_1010_in_ready", 32'(bus.in_ready), 32'(1) << ch);
      exp_q.push_back('{d: dv[ch], s: 2'(ch)});
      step();
    end

    // Manual select stepping 3,2,1,0
    mode = MODE_MANUAL;
    bus.in_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(3 - k);
      #1 chk("man_in_ready", 32'(bus.in_ready), 32'(1) << (3 - k));
      exp_q.push_back('{d: dv[3 - k], s: 2'(3 - k)});
      step();
    end

    // Manual select of an idle channel
    sel = 2'd2;
    bus.in_valid = 4'b1011;
    #1 chk("man_idle_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    chk("man_idle_out_valid", 32'(bus.out_valid), 32'h0);

    // No valid input at all
    sel = 2'd0;
    bus.in_valid = 4'b0000;
    #1 chk("none_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    chk("none_out_valid", 32'(bus.out_valid), 32'h0);

    // Backpressure: hold AA for 3 cycles, then drain+reload with no bubble
    mode = MODE_RR;
    bus.in_valid = 4'b1111;
    #1 chk("bp_load_in_ready", 32'(bus.in_ready), 32'h1);
    exp_q.push_back('{d: dv[0], s: 2'd0});
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      step();
      chk("bp_out_data",  32'(bus.out_data),  32'hAA);
      chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(bus.in_ready), 32'h2);
    exp_q.push_back('{d: dv[1], s: 2'd1});
    step();
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_release_out_src",   32'(bus.out_src),   32'h1);

    // Mid-stream reset with ptr=2 and BB held; consumer stalled so the
    // word would otherwise survive the edge.
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0110;
    #1 chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    void'(exp_q.pop_back());
    step();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'h2);
    exp_q.push_back('{d: dv[1], s: 2'd1});
    step();
    chk("post_rst_out_src", 32'(bus.out_src), 32'h1);

    bus.in_valid = 4'b0000;
    step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    chk("final_out_valid", 32'(bus.out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
